hall98_fetch: RTL and testbench
===============================

# hall98_fetch

Program sequencer that drives the hall98 core's instruction interface (`opcode`, `re`, `n`, `flag`). It holds a small loadable program memory, steps through it, and presents each instruction to the core for a fixed number of cycles. At end of program it raises `flag`. It replaces hand-written stimulus as the source of the core's instruction stream.

## Interface
Parameters:
- `DEPTH`, 16: number of program entries.
- `AW`, 4: address width, `$clog2(DEPTH)`.
- `HOLD_CYCLES`, 50: cycles each instruction is held on the core interface; legal range ≥1.

Ports:
- `iclock`  in  1  system clock; all logic on rising edge.
- `irst_n`  in  1  reset; synchronous, active-low.
- `prog_we`  in  1  program write strobe.
- `prog_addr`  in  AW  program write address.
- `prog_wdata`  in  28  program entry. [7:0] opcode, [11:8] register index, [27:12] signed 16-bit immediate.
- `start`  in  1  single-cycle run request.
- `opcode`  out  32  to core; entry opcode, zero-extended.
- `re`  out  32  to core; register index, zero-extended.
- `n`  out  32  to core; immediate, sign-extended.
- `flag`  out  1  to core; program finished.
- `busy`  out  1  high from the cycle after `start` is accepted until DONE is exited.
- `done`  out  1  one-cycle pulse on completion.
- `err`  out  1  sticky; an illegal opcode was fetched.
- `pc`  out  AW  address of the current or last fetched entry.

## Operation
- Legal opcodes are 0x45 MOV, 0x46 ADD, 0x47 SUB, 0x48 MUL, 0x49 LDR and 0x4A STR. Opcode 0x00 is the terminator. Any other value is illegal.
- States:
  - IDLE: `busy`=0. A `start` pulse sets pc←0, clears `flag` and `err`, and moves to FETCH.
  - FETCH (1 cycle): read mem[pc].
    - Legal opcode: load output registers, set hold counter ← HOLD_CYCLES−1, go to ISSUE.
    - Terminator: go to DONE.
    - Illegal: set `err`, go to DONE.
  - ISSUE: count down the hold counter.
    - At 0 with pc≠DEPTH−1: pc←pc+1, go to FETCH.
    - At 0 with pc=DEPTH−1: go to DONE. There is no wrap; running off the end is treated as a terminator.
  - DONE (1 cycle): `flag`←1, `done`=1, `opcode`/`re`/`n`←0, go to IDLE. `flag` stays high until the next accepted `start`.
- `start` is ignored when not in IDLE.
- `prog_we` writes mem[prog_addr] only when in IDLE. Writes while `busy` are dropped.
- Reset does not clear program memory.
- Reset values: `opcode`=`re`=`n`=0, `flag`=0, `busy`=0, `done`=0, `err`=0, `pc`=0, state=IDLE.
- Reset asserted mid-run: all outputs and state take their reset values on that edge. The run is abandoned and no `done` pulse is produced.

## Timing
- `start` sampled at edge E0 → FETCH during cycle 1 → the first instruction appears on `opcode`/`re`/`n` after edge E2.
- Each instruction is stable for exactly HOLD_CYCLES cycles, followed by 1 FETCH cycle. Issue period is HOLD_CYCLES+1 cycles.
- During FETCH, outputs keep the previous instruction (see Configuration).
- A program of k legal entries plus a terminator: `done` rises k·(HOLD_CYCLES+1)+2 cycles after the `start` edge. `flag` rises on the same edge as `done`.
- A `prog_we` and a `start` in the same IDLE cycle: the write completes, and the following FETCH sees the new data.
- Memory read is combinational within FETCH. The output registers update on the FETCH→ISSUE edge.

## Configuration
- `HALL98_FETCH_GAP_EN` defined:
  - `opcode`, `re` and `n` are forced to 0 during every FETCH cycle, giving a one-cycle NOP between instructions.
  - This lets the core detect back-to-back identical instructions.
  - Period and latency are unchanged.
- Undefined: outputs hold the previous instruction through FETCH.

## Test plan
- Reset, then load {MOV r1,15; STR r1,0; LDR r2,0; term}, start, HOLD_CYCLES=50 → `opcode` shows 0x45/re=1/n=15, then 0x4A/1/0, then 0x49/2/0, each for 50 cycles. `done` and `flag` rise at cycle 155. `err`=0.
- Entry with immediate 0xFFFF → `n`=0xFFFFFFFF. Entry with immediate 0x7FFF → `n`=0x00007FFF.
- Entry 1 has opcode 0x50 → `err`=1 and `flag`=1 after entry 0 completes. Entry 1 is never driven. The next `start` clears `err`.
- All 16 entries legal, no terminator → after the 16th hold, `pc`=15, `done` pulses, no wrap to 0.
- Reset asserted at cycle 30 of a run → on the next edge all outputs are 0 and `busy`=0. A new `start` re-runs the unchanged program. A `prog_we` issued while `busy` leaves memory unchanged.
- With `HALL98_FETCH_GAP_EN`, two identical ADD entries → `opcode` is 0 for exactly one cycle between them. Without the macro, `opcode` stays at 0x46 continuously.

Source files
------------

// File: rtl/hall98_fetch.sv
// hall98_fetch: loadable program sequencer driving the hall98 core instruction interface.
// Define HALL98_FETCH_GAP_EN to zero opcode/re/n during every FETCH cycle.
module hall98_fetch #(
  parameter int DEPTH       = 16,
  parameter int AW          = 4,
  parameter int HOLD_CYCLES = 50
) (
  input  logic          iclock,
  input  logic          irst_n,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [27:0]   prog_wdata,
  input  logic          start,
  output logic [31:0]   opcode,
  output logic [31:0]   re,
  output logic [31:0]   n,
  output logic          flag,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] pc
);
  localparam int CW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, DONE} state_t;
  state_t state_q, state_d;
  logic [27:0] mem [DEPTH];
  logic [27:0] ent;
  logic legal, term;
  logic start_q, start_d, flag_q, flag_d, err_q, err_d;
  logic [31:0] op_q, op_d, re_q, re_d, n_q, n_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] pc_q, pc_d;
  always_ff @(posedge iclock)
    if (prog_we && state_q == IDLE) mem[prog_addr] <= prog_wdata;
  assign ent   = mem[pc_q];
  assign legal = ent[7:0] >= 8'h45 && ent[7:0] <= 8'h4A;
  assign term  = ent[7:0] == 8'h00;
  always_comb begin
    state_d = state_q;
    start_d = start && state_q == IDLE;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    flag_d  = flag_q;
    err_d   = err_q;
    op_d    = op_q;
    re_d    = re_q;
    n_d     = n_q;
    case (state_q)
      IDLE: if (start_q) begin
        pc_d    = '0;
        flag_d  = 1'b0;
        err_d   = 1'b0;
        state_d = FETCH;
      end
      FETCH: if (legal) begin
        op_d    = {24'b0, ent[7:0]};
        re_d    = {28'b0, ent[11:8]};
        n_d     = {{16{ent[27]}}, ent[27:12]};
        cnt_d   = CW'(HOLD_CYCLES - 1);
        state_d = ISSUE;
      end else begin
        err_d   = err_q | ~term;
        state_d = DONE;
      end
      ISSUE: if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        else if (pc_q != AW'(DEPTH - 1)) begin
          pc_d    = pc_q + 1'b1;
          state_d = FETCH;
        end else state_d = DONE;
      default: state_d = IDLE;
    endcase
    // flag and the zeroed outputs appear on the same edge that enters DONE
    if (state_d == DONE) begin
      flag_d = 1'b1;
      op_d   = '0;
      re_d   = '0;
      n_d    = '0;
    end
`ifdef HALL98_FETCH_GAP_EN
    if (state_d == FETCH) begin
      op_d = '0;
      re_d = '0;
      n_d  = '0;
    end
`endif
  end
  always_ff @(posedge iclock)
    if (!irst_n) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      pc_q    <= '0;
      cnt_q   <= '0;
      flag_q  <= 1'b0;
      err_q   <= 1'b0;
      op_q    <= '0;
      re_q    <= '0;
      n_q     <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      flag_q  <= flag_d;
      err_q   <= err_d;
      op_q    <= op_d;
      re_q    <= re_d;
      n_q     <= n_d;
    end
  assign opcode = op_q;
  assign re     = re_q;
  assign n      = n_q;
  assign flag   = flag_q;
  assign err    = err_q;
  assign pc     = pc_q;
  assign busy   = state_q != IDLE;
  assign done   = state_q == DONE;
endmodule

// File: tb/tb_hall98_fetch.sv
// tb_hall98_fetch: scoreboard bench for hall98_fetch; expected instructions queued at start, checked as issued.
module tb_hall98_fetch;
  localparam int H = 50;
  localparam int DEPTH = 16;
  logic iclock = 1'b0, irst_n = 1'b0, prog_we = 1'b0, start = 1'b0;
  logic [3:0] prog_addr = '0;
  logic [27:0] prog_wdata = '0;
  logic [31:0] opcode, re, n;
  logic flag, busy, done, err;
  logic [3:0] pc;
  typedef struct { logic [31:0] op, r, imm; } exp_t;
  exp_t sb[$];
  logic [27:0] prog [DEPTH];
  int total = 0, bad = 0;

  hall98_fetch dut (
    .iclock(iclock), .irst_n(irst_n), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_wdata(prog_wdata), .start(start), .opcode(opcode), .re(re), .n(n),
    .flag(flag), .busy(busy), .done(done), .err(err), .pc(pc)
  );

  always #5 iclock = ~iclock;

  function automatic logic [27:0] mk(input logic [7:0] op, input logic [3:0] r, input logic [15:0] imm);
    return {imm, r, op};
  endfunction

  task automatic wr(input int a, input logic [27:0] d);
    @(negedge iclock);
    prog_we = 1'b1; prog_addr = 4'(a); prog_wdata = d;
    @(negedge iclock);
    prog_we = 1'b0;
    prog[a] = d;
  endtask

  task automatic run(input bit poke);
    int k, kind, exp_done, c, ph, idx;
    bit seen;
    exp_t cur;
    k = 0; kind = 2;
    for (int i = 0; i < DEPTH; i++) begin
      if (prog[i][7:0] inside {[8'h45:8'h4A]}) begin
        sb.push_back('{{24'b0, prog[i][7:0]}, {28'b0, prog[i][11:8]}, {{16{prog[i][27]}}, prog[i][27:12]}});
        k++;
      end else begin
        kind = prog[i][7:0] == 8'h00 ? 0 : 1;
        break;
      end
    end
    exp_done = kind == 2 ? k * (H + 1) + 1 : k * (H + 1) + 2;
    @(negedge iclock); start = 1'b1;
    @(posedge iclock); #1 start = 1'b0;
    c = 0; seen = 1'b0; cur = '{0, 0, 0};
    while (!seen && c < exp_done + 10) begin
      @(posedge iclock); #1 c++;
      if (poke && c == 5) begin prog_we = 1'b1; prog_addr = 4'd0; prog_wdata = mk(8'h50, 4'd9, 16'h1234); end
      if (poke && c == 6) prog_we = 1'b0;
      if (c == 1) begin
        total++;
        if ({busy, flag, err} !== 3'b100) begin bad++; $display("FAIL accept busy/flag/err=%b want 100", {busy, flag, err}); end
      end
      if (done) begin
        seen = 1'b1;
        total++;
        if (c !== exp_done) begin bad++; $display("FAIL done_cycle got %0d want %0d", c, exp_done); end
        total++;
        if ({flag, err} !== {1'b1, kind == 1}) begin bad++; $display("FAIL done_flag_err got %b want %b", {flag, err}, {1'b1, kind == 1}); end
        total++;
        if (pc !== 4'(kind == 2 ? DEPTH - 1 : k)) begin bad++; $display("FAIL done_pc got %0d want %0d", pc, kind == 2 ? DEPTH - 1 : k); end
        total++;
        if ({opcode, re, n} !== 96'b0 || sb.size() != 0) begin bad++; $display("FAIL done_clear op=%h re=%h n=%h left=%0d", opcode, re, n, sb.size()); end
      end else if (c >= 2) begin
        ph = (c - 2) % (H + 1); idx = (c - 2) / (H + 1);
        if (idx < k && (ph == 0 || ph == H - 1)) begin
          if (ph == 0) cur = sb.pop_front();
          total++;
          if (opcode !== cur.op || re !== cur.r || n !== cur.imm) begin
            bad++; $display("FAIL issue%0d_ph%0d got %h/%h/%h want %h/%h/%h", idx, ph, opcode, re, n, cur.op, cur.r, cur.imm);
          end
        end
        if (idx < k - 1 && ph == H) begin
          total++;
`ifdef HALL98_FETCH_GAP_EN
          if (opcode !== 32'h0) begin bad++; $display("FAIL gap%0d got %h want 0", idx, opcode); end
`else
          if (opcode !== cur.op) begin bad++; $display("FAIL hold%0d got %h want %h", idx, opcode, cur.op); end
`endif
        end
      end
    end
    if (!seen) begin total++; bad++; $display("FAIL done_timeout after %0d cycles", c); end
    sb.delete();
    @(posedge iclock); #1 total++;
    if ({done, busy, flag} !== 3'b001) begin bad++; $display("FAIL after_done done/busy/flag=%b want 001", {done, busy, flag}); end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge iclock);
    #1 total++;
    if ({opcode, re, n, flag, busy, done, err, pc} !== 104'b0) begin
      bad++; $display("FAIL reset op=%h re=%h n=%h f=%b b=%b d=%b e=%b pc=%0d", opcode, re, n, flag, busy, done, err, pc);
    end
    irst_n = 1'b1;
  endtask

  task automatic test_basic;
    wr(0, mk(8'h45, 4'd1, 16'd15));
    wr(1, mk(8'h4A, 4'd1, 16'd0));
    wr(2, mk(8'h49, 4'd2, 16'd0));
    wr(3, 28'h0);
    run(1'b0);
  endtask

  task automatic test_sign_ext;
    wr(0, mk(8'h46, 4'd3, 16'hFFFF));
    wr(1, mk(8'h47, 4'd4, 16'h7FFF));
    wr(2, 28'h0);
    run(1'b0);
  endtask

  task automatic test_illegal;
    wr(0, mk(8'h48, 4'd5, 16'h8000));
    wr(1, mk(8'h50, 4'd6, 16'd1));
    wr(2, 28'h0);
    run(1'b0);
    wr(0, 28'h0);
    run(1'b0);
  endtask

  task automatic test_full;
    for (int i = 0; i < DEPTH; i++) wr(i, mk(8'(8'h45 + i % 6), 4'(i), 16'(i * 1000 - 3000)));
    run(1'b0);
  endtask

  task automatic test_reset_mid;
    wr(0, mk(8'h45, 4'd1, 16'd15));
    wr(1, mk(8'h4A, 4'd1, 16'd0));
    wr(2, 28'h0);
    @(negedge iclock); start = 1'b1;
    @(posedge iclock); #1 start = 1'b0;
    repeat (29) @(posedge iclock);
    #1 total++;
    if (busy !== 1'b1 || opcode !== 32'h45) begin bad++; $display("FAIL mid_run busy=%b op=%h want 1/45", busy, opcode); end
    @(negedge iclock); irst_n = 1'b0;
    @(posedge iclock); #1 total++;
    if ({opcode, re, n, flag, busy, done, err, pc} !== 104'b0) begin
      bad++; $display("FAIL mid_reset op=%h re=%h n=%h f=%b b=%b d=%b e=%b pc=%0d", opcode, re, n, flag, busy, done, err, pc);
    end
    @(negedge iclock); irst_n = 1'b1;
    run(1'b1);
    run(1'b0);
  endtask

  task automatic test_back_to_back;
    wr(0, mk(8'h46, 4'd7, 16'd3));
    wr(1, mk(8'h46, 4'd7, 16'd3));
    wr(2, 28'h0);
    run(1'b0);
    @(negedge iclock);
    prog_we = 1'b1; prog_addr = 4'd0; prog_wdata = mk(8'h47, 4'd2, 16'hFFFE);
    prog[0] = prog_wdata;
    run(1'b0);
    prog_we = 1'b0;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_sign_ext;
    test_illegal;
    test_full;
    test_reset_mid;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
